// File: rtl/int_ctrl_if.sv
// Signal bundle between the branch unit / fetch side and the interrupt controller.
// The master modport is the environment and the slave modport is the controller.
interface int_ctrl_if;
    logic        sw_int_set;
    logic [31:0] sw_int_type;
    logic        int_ret;
    logic [31:0] hw_irq;
    logic        mask_we;
    logic [31:0] mask_wdata;
    logic        irq_ack;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic [31:0] irq_vec;
    logic [31:0] pending;
    logic [31:0] in_service;
    logic [31:0] mask;

    modport master (
        output sw_int_set, sw_int_type, int_ret, hw_irq, mask_we, mask_wdata, irq_ack,
        input  irq_req, irq_id, irq_vec, pending, in_service, mask
    );

    modport slave (
        input  sw_int_set, sw_int_type, int_ret, hw_irq, mask_we, mask_wdata, irq_ack,
        output irq_req, irq_id, irq_vec, pending, in_service, mask
    );
endinterface

// File: rtl/int_ctrl.sv
// Fixed-priority nesting interrupt controller: pending/mask/in-service tracking
// and a one-at-a-time request/acknowledge handoff to instruction fetch.
module int_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    int_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] in_service_q, in_service_d;
    logic [31:0] mask_q, mask_d;
    logic [4:0]  irq_id_q, irq_id_d;
    logic [31:0] irq_vec_q, irq_vec_d;

    logic        ack_fire;
    logic [31:0] ack_onehot;
    logic [31:0] isv_top;
    logic [31:0] allowed;
    logic [4:0]  cand_idx;

    function automatic logic [4:0] lsb_idx(input logic [31:0] v);
        lsb_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lsb_idx = 5'(i);
        end
    endfunction

    function automatic logic [31:0] vec_addr(input logic [4:0] id);
        vec_addr = VEC_BASE + 32'(id) * VEC_STRIDE;
    endfunction

    // Bit 0 is highest priority, so the highest in-service bit is the lowest set
    // bit; everything strictly below it in index may preempt (all bits if none).
    assign isv_top  = in_service_q & (~in_service_q + 32'd1);
    assign allowed  = pending_q & ~mask_q & (isv_top - 32'd1);
    assign cand_idx = lsb_idx(allowed);

    assign ack_fire   = (state_q == REQ) && bus.irq_ack;
    assign ack_onehot = ack_fire ? (32'd1 << irq_id_q) : 32'd0;

    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        irq_vec_d    = irq_vec_q;
        pending_d    = (pending_q & ~ack_onehot) | bus.hw_irq |
                       (bus.sw_int_set ? bus.sw_int_type : 32'd0);
        in_service_d = (in_service_q & ~(bus.int_ret ? isv_top : 32'd0)) | ack_onehot;
        mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
        case (state_q)
            IDLE: begin
                if (allowed != 32'd0) begin
                    irq_id_d  = cand_idx;
                    irq_vec_d = vec_addr(cand_idx);
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            irq_id_q     <= '0;
            irq_vec_q    <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            irq_id_q     <= irq_id_d;
            irq_vec_q    <= irq_vec_d;
        end
    end

    assign bus.irq_req    = (state_q == REQ);
    assign bus.irq_id     = irq_id_q;
    assign bus.irq_vec    = irq_vec_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.mask       = mask_q;

endmodule
